// File: rtl/pwm_capture_pkg.sv
// Shared types and defaults for the pulse-train capture block.
package pwm_capture_pkg;

   localparam int DEF_RAM_WIDTH   = 32'd32;
   localparam int DEF_SYNC_STAGES = 32'd2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ARM    = 3'd1,
      ST_ACTIVE = 3'd2,
      ST_GAP    = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   // Maps the raw pin level to "1 = active" whatever the idle polarity is.
   function automatic logic active_level(input logic raw, input logic idle_level);
      return raw ^ idle_level;
   endfunction

endpackage

// File: rtl/pwm_capture_pulse_in_sync.sv
// Synchroniser chain plus one edge register; edges are reported in active-level terms
// (rise = entering the active level, fall = returning to the idle level).
module pwm_capture_pulse_in_sync
   import pwm_capture_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic default_level,
   input  logic pulse_in,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   prev_r;
   logic                   level_s;

   assign level_s = active_level(sync_r[SYNC_STAGES-1], default_level);

   // Synchroniser shift chain, preloaded with the idle level so reset never looks like an edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_r <= {SYNC_STAGES{default_level}};
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], pulse_in};
      end
   end

   // Edge register holding the previous normalised level.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prev_r <= 1'b0;
      end else begin
         prev_r <= level_s;
      end
   end

   assign rise = level_s & ~prev_r;
   assign fall = ~level_s & prev_r;

endmodule

// File: rtl/pwm_capture.sv
// Pulse-train capture: active width, gap width and pulse count per burst.
// Widths are counted on the synchronised input, so an N-clock pulse reads exactly N.
module pwm_capture
   import pwm_capture_pkg::*;
#(
   parameter int _RAM_WIDTH  = DEF_RAM_WIDTH,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic                  io_clk,
   input  logic                  io_rst,
   input  logic                  io_en,
   input  logic                  io_pulseIn,
   input  logic                  io_defaultLevel,
   input  logic [_RAM_WIDTH-1:0] io_pusle_times,
   input  logic [_RAM_WIDTH-1:0] io_timeout,
   output logic [_RAM_WIDTH-1:0] meas_pulseWidth,
   output logic [_RAM_WIDTH-1:0] meas_unaccessWidth,
   output logic [_RAM_WIDTH-1:0] meas_count,
   output logic                  width_valid,
   output logic                  gap_valid,
   output logic                  capture_busy,
   output logic                  capture_done,
   output logic                  err_timeout,
   output logic                  err_overflow
);

   localparam logic [_RAM_WIDTH-1:0] ZERO     = {_RAM_WIDTH{1'b0}};
   localparam logic [_RAM_WIDTH-1:0] ONE      = {{(_RAM_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [_RAM_WIDTH-1:0] ALL_ONES = {_RAM_WIDTH{1'b1}};

   state_t                  state_r;
   logic                    en_prev_r;
   logic [_RAM_WIDTH-1:0]   times_r;
   logic [_RAM_WIDTH-1:0]   timeout_r;
   logic [_RAM_WIDTH-1:0]   width_cnt_r;
   logic [_RAM_WIDTH-1:0]   gap_cnt_r;
   logic [_RAM_WIDTH-1:0]   width_r;
   logic [_RAM_WIDTH-1:0]   gap_r;
   logic [_RAM_WIDTH-1:0]   count_r;
   logic                    width_valid_r;
   logic                    gap_valid_r;
   logic                    busy_r;
   logic                    done_r;
   logic                    err_timeout_r;
   logic                    err_overflow_r;

   logic                    rise_s;
   logic                    fall_s;
   logic                    arm_s;
   logic                    timeout_hit_s;
   logic [_RAM_WIDTH-1:0]   count_next_s;

   function automatic logic [_RAM_WIDTH-1:0] sat_inc(input logic [_RAM_WIDTH-1:0] value);
      logic [_RAM_WIDTH-1:0] result;
      if (value == ALL_ONES) begin
         result = value;
      end else begin
         result = value + ONE;
      end
      return result;
   endfunction

   pwm_capture_pulse_in_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk          (io_clk),
      .rst_n        (io_rst),
      .default_level(io_defaultLevel),
      .pulse_in     (io_pulseIn),
      .rise         (rise_s),
      .fall         (fall_s)
   );

   assign arm_s        = io_en & ~en_prev_r;
   assign count_next_s = sat_inc(count_r);
   // The current gap cycle is gap_cnt_r + 1, so the limit is reached one count early.
   assign timeout_hit_s = (timeout_r != ZERO) && (gap_cnt_r >= (timeout_r - ONE));

   // Capture FSM, counters and result registers.
   always_ff @(posedge io_clk) begin
      if (!io_rst) begin
         state_r        <= ST_IDLE;
         en_prev_r      <= 1'b0;
         times_r        <= ZERO;
         timeout_r      <= ZERO;
         width_cnt_r    <= ZERO;
         gap_cnt_r      <= ZERO;
         width_r        <= ZERO;
         gap_r          <= ZERO;
         count_r        <= ZERO;
         width_valid_r  <= 1'b0;
         gap_valid_r    <= 1'b0;
         busy_r         <= 1'b0;
         done_r         <= 1'b0;
         err_timeout_r  <= 1'b0;
         err_overflow_r <= 1'b0;
      end else begin
         en_prev_r     <= io_en;
         width_valid_r <= 1'b0;
         gap_valid_r   <= 1'b0;
         done_r        <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (arm_s) begin
                  times_r        <= io_pusle_times;
                  timeout_r      <= io_timeout;
                  count_r        <= ZERO;
                  err_timeout_r  <= 1'b0;
                  err_overflow_r <= 1'b0;
                  busy_r         <= 1'b1;
                  state_r        <= ST_ARM;
               end
            end
            ST_ARM: begin
               if (!io_en) begin
                  done_r  <= 1'b1;
                  busy_r  <= 1'b0;
                  state_r <= ST_IDLE;
               end else if (rise_s) begin
                  width_cnt_r <= ONE;
                  state_r     <= ST_ACTIVE;
               end
            end
            ST_ACTIVE: begin
               if (!io_en) begin
                  done_r  <= 1'b1;
                  busy_r  <= 1'b0;
                  state_r <= ST_IDLE;
               end else if (fall_s) begin
                  width_r       <= width_cnt_r;
                  width_valid_r <= 1'b1;
                  count_r       <= count_next_s;
                  if (count_r == ALL_ONES) begin
                     err_overflow_r <= 1'b1;
                  end
                  gap_cnt_r <= ONE;
                  if ((times_r != ZERO) && (count_next_s == times_r)) begin
                     state_r <= ST_DONE;
                  end else if (timeout_r == ONE) begin
                     err_timeout_r <= 1'b1;
                     state_r       <= ST_DONE;
                  end else begin
                     state_r <= ST_GAP;
                  end
               end else begin
                  width_cnt_r <= sat_inc(width_cnt_r);
                  if (width_cnt_r == ALL_ONES) begin
                     err_overflow_r <= 1'b1;
                  end
               end
            end
            ST_GAP: begin
               if (!io_en) begin
                  done_r  <= 1'b1;
                  busy_r  <= 1'b0;
                  state_r <= ST_IDLE;
               end else if (rise_s) begin
                  gap_r       <= gap_cnt_r;
                  gap_valid_r <= 1'b1;
                  width_cnt_r <= ONE;
                  state_r     <= ST_ACTIVE;
               end else if (timeout_hit_s) begin
                  err_timeout_r <= 1'b1;
                  state_r       <= ST_DONE;
               end else begin
                  gap_cnt_r <= sat_inc(gap_cnt_r);
                  if (gap_cnt_r == ALL_ONES) begin
                     err_overflow_r <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               done_r  <= 1'b1;
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign meas_pulseWidth    = width_r;
   assign meas_unaccessWidth = gap_r;
   assign meas_count         = count_r;
   assign width_valid        = width_valid_r;
   assign gap_valid          = gap_valid_r;
   assign capture_busy       = busy_r;
   assign capture_done       = done_r;
   assign err_timeout        = err_timeout_r;
   assign err_overflow       = err_overflow_r;

endmodule
